// File: rtl/cordic_span_scheduler.sv
// cordic_span_scheduler: round-robin span arbiter that expands spans into credit-throttled CORDIC tokens.
// Optional CORDIC_SCHED_STATS_EN adds stat_tokens/stat_stalls/stat_spans counters.
module cordic_span_scheduler #(
  parameter int NREQ = 2,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*9-1:0] req_color,
  input  logic [NREQ*10-1:0] req_pixel_y,
  input  logic [NREQ*10-1:0] req_x_start,
  input  logic [NREQ*10-1:0] req_x_len,
  input  logic [NREQ*9-1:0] req_ref_x,
  input  logic [NREQ*9-1:0] req_ref_y,
  input  logic [NREQ-1:0]   req_form,
  input  logic [NREQ*9-1:0] req_angle,
  input  logic              ret_valid,
  output logic              out_bubble,
  output logic [8:0]        out_color,
  output logic [9:0]        out_pixel_x,
  output logic [9:0]        out_pixel_y,
  output logic [8:0]        out_ref_point_x,
  output logic [8:0]        out_ref_point_y,
  output logic              out_form,
  output logic [8:0]        out_angle,
  output logic              out_enable_cordic,
  output logic [1:0]        out_grant_id,
  output logic              credit_err
`ifdef CORDIC_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_tokens,
  output logic [31:0]       stat_stalls,
  output logic [15:0]       stat_spans
`endif
);
  typedef enum logic {IDLE, ISSUE} state_t;
  localparam logic [3:0] CMAX = 4'(CREDITS);
  state_t state;
  logic [3:0] credits;
  logic [1:0] rr_ptr, g;
  logic [9:0] rem;
  logic found, grant, issue, ret_ok;
  logic [8:0] sel_color, sel_ref_x, sel_ref_y, sel_angle;
  logic [9:0] sel_y, sel_x, sel_len;
  logic sel_form;
  // Two passes give the rotating priority: indices at or above rr_ptr first, then wrap.
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int k = 0; k < NREQ; k++)
      if (!found && req_valid[k] && 2'(k) >= rr_ptr) begin
        found = 1'b1;
        g = 2'(k);
      end
    for (int k = 0; k < NREQ; k++)
      if (!found && req_valid[k]) begin
        found = 1'b1;
        g = 2'(k);
      end
    sel_color = '0;
    sel_ref_x = '0;
    sel_ref_y = '0;
    sel_angle = '0;
    sel_y = '0;
    sel_x = '0;
    sel_len = '0;
    sel_form = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (g == 2'(k)) begin
        sel_color = req_color[k*9 +: 9];
        sel_ref_x = req_ref_x[k*9 +: 9];
        sel_ref_y = req_ref_y[k*9 +: 9];
        sel_angle = req_angle[k*9 +: 9];
        sel_y = req_pixel_y[k*10 +: 10];
        sel_x = req_x_start[k*10 +: 10];
        sel_len = req_x_len[k*10 +: 10];
        sel_form = req_form[k];
      end
    grant = state == IDLE && found && (credits != 4'd0 || sel_len == 10'd0);
    for (int k = 0; k < NREQ; k++) req_ready[k] = grant && g == 2'(k);
    issue = grant ? sel_len != 10'd0 : state == ISSUE && credits != 4'd0;
    ret_ok = ret_valid && credits != CMAX;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      credits <= CMAX;
      rr_ptr <= '0;
      rem <= '0;
      credit_err <= 1'b0;
      out_bubble <= 1'b1;
      out_color <= '0;
      out_pixel_x <= '0;
      out_pixel_y <= '0;
      out_ref_point_x <= '0;
      out_ref_point_y <= '0;
      out_form <= 1'b0;
      out_angle <= '0;
      out_enable_cordic <= 1'b0;
      out_grant_id <= '0;
    end else begin
      credits <= credits - {3'b0, issue} + {3'b0, ret_ok};
      credit_err <= credit_err | (ret_valid && credits == CMAX);
      out_bubble <= !issue;
      if (grant) begin
        rr_ptr <= g == 2'(NREQ - 1) ? 2'd0 : g + 2'd1;
        if (sel_len != 10'd0) begin
          out_color <= sel_color;
          out_pixel_x <= sel_x;
          out_pixel_y <= sel_y;
          out_ref_point_x <= sel_ref_x;
          out_ref_point_y <= sel_ref_y;
          out_form <= sel_form;
          out_angle <= sel_angle;
          out_enable_cordic <= 1'b1;
          out_grant_id <= g;
          rem <= sel_len - 10'd1;
          state <= sel_len == 10'd1 ? IDLE : ISSUE;
        end
      end else if (state == ISSUE && credits != 4'd0) begin
        out_pixel_x <= out_pixel_x + 10'd1;
        out_enable_cordic <= 1'b0;
        rem <= rem - 10'd1;
        state <= rem == 10'd1 ? IDLE : ISSUE;
      end
    end
`ifdef CORDIC_SCHED_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      stat_tokens <= '0;
      stat_stalls <= '0;
      stat_spans <= '0;
    end else begin
      stat_tokens <= stat_tokens + {31'b0, issue};
      stat_stalls <= stat_stalls + {31'b0, state == ISSUE && credits == 4'd0};
      stat_spans <= stat_spans + {15'b0, grant};
    end
`endif
endmodule

// File: tb/tb_cordic_span_scheduler.sv
// tb_cordic_span_scheduler: randomized and directed checks against a span/token queue model.
module tb_cordic_span_scheduler;
  localparam int NREQ = 2;
  localparam int CREDITS = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*9-1:0] req_color, req_ref_x, req_ref_y, req_angle;
  logic [NREQ*10-1:0] req_pixel_y, req_x_start, req_x_len;
  logic [NREQ-1:0] req_form;
  logic ret_valid;
  logic out_bubble, out_form, out_enable_cordic, credit_err;
  logic [8:0] out_color, out_ref_point_x, out_ref_point_y, out_angle;
  logic [9:0] out_pixel_x, out_pixel_y;
  logic [1:0] out_grant_id;
`ifdef CORDIC_SCHED_STATS_EN
  logic [31:0] stat_tokens, stat_stalls;
  logic [15:0] stat_spans;
`endif
  logic [8:0] rp_color[NREQ], rp_ref_x[NREQ], rp_ref_y[NREQ], rp_angle[NREQ];
  logic [9:0] rp_y[NREQ], rp_x[NREQ], rp_len[NREQ];
  logic rp_form[NREQ];
  always_comb
    for (int k = 0; k < NREQ; k++) begin
      req_color[k*9 +: 9] = rp_color[k];
      req_ref_x[k*9 +: 9] = rp_ref_x[k];
      req_ref_y[k*9 +: 9] = rp_ref_y[k];
      req_angle[k*9 +: 9] = rp_angle[k];
      req_pixel_y[k*10 +: 10] = rp_y[k];
      req_x_start[k*10 +: 10] = rp_x[k];
      req_x_len[k*10 +: 10] = rp_len[k];
      req_form[k] = rp_form[k];
    end
  cordic_span_scheduler #(.NREQ(NREQ), .CREDITS(CREDITS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_color(req_color), .req_pixel_y(req_pixel_y), .req_x_start(req_x_start),
    .req_x_len(req_x_len), .req_ref_x(req_ref_x), .req_ref_y(req_ref_y),
    .req_form(req_form), .req_angle(req_angle), .ret_valid(ret_valid),
    .out_bubble(out_bubble), .out_color(out_color), .out_pixel_x(out_pixel_x),
    .out_pixel_y(out_pixel_y), .out_ref_point_x(out_ref_point_x),
    .out_ref_point_y(out_ref_point_y), .out_form(out_form), .out_angle(out_angle),
    .out_enable_cordic(out_enable_cordic), .out_grant_id(out_grant_id),
    .credit_err(credit_err)
`ifdef CORDIC_SCHED_STATS_EN
    , .stat_tokens(stat_tokens), .stat_stalls(stat_stalls), .stat_spans(stat_spans)
`endif
  );
  typedef struct {
    logic [9:0] x, y;
    logic [8:0] color, rx, ry, angle;
    logic form, en;
    logic [1:0] gid;
  } tok_t;
  tok_t pend[$];
  int vectors = 0, miscompares = 0;
  int m_credits, m_rr, st_tok, st_stall, st_span;
  bit m_err;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_req(int i, int len, int xs);
    rp_len[i] = 10'(len);
    rp_x[i] = 10'(xs);
    rp_y[i] = 10'($urandom);
    rp_color[i] = 9'($urandom);
    rp_ref_x[i] = 9'($urandom);
    rp_ref_y[i] = 9'($urandom);
    rp_angle[i] = 9'($urandom);
    rp_form[i] = 1'($urandom);
    req_valid[i] = 1'b1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    ret_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend.delete();
    m_credits = CREDITS;
    m_rr = 0;
    m_err = 0;
    st_tok = 0;
    st_stall = 0;
    st_span = 0;
    check("rst_bubble", 32'(out_bubble), 1);
    check("rst_err", 32'(credit_err), 0);
    check("rst_x", 32'(out_pixel_x), 0);
    check("rst_en", 32'(out_enable_cordic), 0);
    check("rst_gid", 32'(out_grant_id), 0);
`ifdef CORDIC_SCHED_STATS_EN
    check("rst_stat_tokens", stat_tokens, 0);
`endif
  endtask
  // One clock: inputs are already applied; model decides, then outputs are compared after the edge.
  task automatic step();
    int g;
    bit grant, iss, full;
    tok_t t;
    #1;
    g = -1;
    if (pend.size() == 0)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    grant = g >= 0 && (m_credits > 0 || rp_len[g] == 0);
    check("req_ready", 32'(req_ready), grant ? 32'(1) << g : 0);
    iss = 0;
    if (pend.size() > 0 && m_credits == 0) st_stall++;
    if (grant) begin
      st_span++;
      m_rr = (g + 1) % NREQ;
      for (int i = 0; i < int'(rp_len[g]); i++) begin
        t.x = 10'((int'(rp_x[g]) + i) % 1024);
        t.y = rp_y[g];
        t.color = rp_color[g];
        t.rx = rp_ref_x[g];
        t.ry = rp_ref_y[g];
        t.angle = rp_angle[g];
        t.form = rp_form[g];
        t.en = i == 0;
        t.gid = 2'(g);
        pend.push_back(t);
      end
      if (rp_len[g] != 0) iss = 1;
    end else if (pend.size() > 0 && m_credits > 0) iss = 1;
    if (iss) begin
      t = pend.pop_front();
      st_tok++;
    end
    full = m_credits == CREDITS;
    if (ret_valid && full) m_err = 1;
    if (ret_valid && !full) m_credits++;
    if (iss) m_credits--;
    @(posedge clk);
    #1;
    check("bubble", 32'(out_bubble), 32'(!iss));
    if (iss) begin
      check("pixel_x", 32'(out_pixel_x), 32'(t.x));
      check("pixel_y", 32'(out_pixel_y), 32'(t.y));
      check("color", 32'(out_color), 32'(t.color));
      check("ref", {out_ref_point_x, out_ref_point_y}, {14'd0, t.rx, t.ry});
      check("angle_form", {out_angle, out_form}, {22'd0, t.angle, t.form});
      check("enable_cordic", 32'(out_enable_cordic), 32'(t.en));
      check("grant_id", 32'(out_grant_id), 32'(t.gid));
    end
    check("credit_err", 32'(credit_err), 32'(m_err));
`ifdef CORDIC_SCHED_STATS_EN
    check("stat_tokens", stat_tokens, 32'(st_tok));
    check("stat_stalls", stat_stalls, 32'(st_stall));
    check("stat_spans", 32'(stat_spans), 32'(st_span % 65536));
`endif
    if (grant) req_valid[g] = 1'b0;
  endtask
  initial begin
    for (int k = 0; k < NREQ; k++) set_req(k, 0, 0);
    do_reset();
    set_req(0, 3, 100);
    repeat (5) step();
    do_reset();
    set_req(0, 6, 200);
    repeat (10) step();
    for (int i = 0; i < 14; i++) begin
      ret_valid = i % 2 == 0 && m_credits < CREDITS;
      step();
    end
    ret_valid = 1'b0;
    for (int r = 0; r < 6; r++) begin
      if (!req_valid[0]) set_req(0, 2, 10 * r);
      if (!req_valid[1]) set_req(1, 2, 500 + r);
      ret_valid = m_credits < CREDITS;
      step();
    end
    do_reset();
    set_req(0, 4, 7);
    repeat (5) step();
    set_req(0, 1, 33);
    set_req(1, 0, 44);
    repeat (3) step();
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    repeat (3) step();
    do_reset();
    set_req(0, 4, 1022);
    repeat (6) begin
      ret_valid = m_credits < CREDITS;
      step();
    end
    ret_valid = 1'b1;
    repeat (2) step();
    ret_valid = 1'b0;
    repeat (3) step();
    do_reset();
    set_req(0, 5, 300);
    repeat (2) step();
    do_reset();
    repeat (4) step();
    set_req(1, 4, 900);
    repeat (6) step();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NREQ; k++)
        if (!req_valid[k] && $urandom_range(0, 3) == 0)
          set_req(k, $urandom_range(0, 7), $urandom_range(0, 1023));
      ret_valid = m_credits < CREDITS ? $urandom_range(0, 1) == 1 : $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
